// File: rtl/md_pkg.sv
// Shared MD-core definitions used by the home-cell read controller.
package md_pkg;

  localparam int unsigned DEFAULT_NUM_FILTER         = 7;
  localparam int unsigned DEFAULT_NUM_NEIGHBOR_CELLS = 13;
  localparam int unsigned DEFAULT_PARTICLE_ID_WIDTH  = 7;

  // Home cell plus its neighbours.
  localparam int unsigned NUM_CELLS = DEFAULT_NUM_NEIGHBOR_CELLS + 1;

  // Counts carry one extra bit so a full cell (2**PARTICLE_ID_WIDTH) is representable.
  typedef logic [DEFAULT_PARTICLE_ID_WIDTH:0] count_t;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad0  = 3'd1,
    StSweep0 = 3'd2,
    StLoad1  = 3'd3,
    StSweep1 = 3'd4,
    StFinish = 3'd5
  } rdctl_state_t;

endpackage

// File: rtl/ref_index_bank.sv
// Per-cell reference index counters, per-phase increment and exhaustion tracking.
module ref_index_bank
  import md_pkg::*;
#(
  parameter int unsigned NUM_FILTER        = 7,
  parameter int unsigned CELLS             = NUM_CELLS,
  parameter int unsigned PARTICLE_ID_WIDTH = 7
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    clear,
  input  logic [CELLS*(PARTICLE_ID_WIDTH+1)-1:0]  count_in,
  input  logic                                    load,
  input  logic                                    inc,
  input  logic                                    phase,
  output logic [PARTICLE_ID_WIDTH:0]              home_count,
  output logic [PARTICLE_ID_WIDTH:0]              ref0,
  output logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0] ref_addr,
  output logic                                    phase_all_done,
  output logic [CELLS-1:0]                        broadcast_done
);

  localparam int unsigned CW = PARTICLE_ID_WIDTH + 1;
  localparam int unsigned PW = PARTICLE_ID_WIDTH;

  logic [CW-1:0]    cnt_q [CELLS];
  logic [CW-1:0]    r_q   [CELLS];
  logic [CELLS-1:0] bd_q;
  logic [CELLS-1:0] done_now;
  logic [CELLS-1:0] in_phase;

  // Exhaustion compare and phase membership of every cell.
  always_comb begin
    done_now = '0;
    in_phase = '0;
    for (int i = 0; i < CELLS; i++) begin
      done_now[i] = (r_q[i] >= cnt_q[i]);
      in_phase[i] = ((i / NUM_FILTER) == 32'(phase));
    end
  end

  // Cells outside the current phase never block the skip decision.
  assign phase_all_done = &(done_now | ~in_phase);

  assign home_count     = cnt_q[0];
  assign ref0           = r_q[0];
  assign broadcast_done = bd_q;

  for (genvar k = 0; k < NUM_FILTER; k++) begin : g_lane
    if (NUM_FILTER + k < CELLS) begin : g_both
      assign ref_addr[k*PW +: PW] = phase ? r_q[NUM_FILTER+k][PW-1:0] : r_q[k][PW-1:0];
    end else begin : g_low
      assign ref_addr[k*PW +: PW] = phase ? '0 : r_q[k][PW-1:0];
    end
  end

  // Count latch, reference counters and sticky done flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) begin
        cnt_q[i] <= '0;
        r_q[i]   <= '0;
      end
      bd_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < CELLS; i++) begin
        cnt_q[i] <= count_in[i*CW +: CW];
        r_q[i]   <= '0;
      end
      bd_q <= '0;
    end else begin
      if (load) begin
        bd_q <= bd_q | done_now;
      end
      if (inc) begin
        for (int i = 0; i < CELLS; i++) begin
          if (in_phase[i] && !done_now[i]) begin
            r_q[i] <= r_q[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/home_cell_read_controller.sv
// Sequences home-cell reads against per-lane reference particles and
// generates the data-aligned sideband for the position data distributor.
module home_cell_read_controller
  import md_pkg::*;
#(
  parameter int unsigned NUM_FILTER         = 7,
  parameter int unsigned NUM_NEIGHBOR_CELLS = 13,
  parameter int unsigned PARTICLE_ID_WIDTH  = 7
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  start,
  input  logic [(NUM_NEIGHBOR_CELLS+1)*(PARTICLE_ID_WIDTH+1)-1:0] cell_particle_count,
  input  logic                                                  back_pressure,
  output logic                                                  home_rd_en,
  output logic [PARTICLE_ID_WIDTH-1:0]                          home_rd_addr,
  output logic                                                  ref_load,
  output logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0]               ref_rd_addr,
  output logic                                                  phase,
  output logic                                                  pause_reading,
  output logic [NUM_NEIGHBOR_CELLS:0]                           broadcast_done,
  output logic                                                  ref_particle_read,
  output logic                                                  busy,
  output logic                                                  done
);

  localparam int unsigned CELLS = NUM_NEIGHBOR_CELLS + 1;
  localparam int unsigned CW    = PARTICLE_ID_WIDTH + 1;

  rdctl_state_t  state_q, state_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] home_count;
  logic [CW-1:0] ref0;
  logic          cur_phase;
  logic          issue;
  logic          last_issue;
  logic          start_accept;
  logic          load;
  logic          inc;
  logic          phase_all_done;
  logic          pause_q;
  logic          phase_q;
  logic          rpr_q;
  logic          done_q;

  assign cur_phase  = (state_q == StLoad1) || (state_q == StSweep1);
  assign issue      = ((state_q == StSweep0) || (state_q == StSweep1)) && !back_pressure;
  // Full-width compare so a count of 2**PARTICLE_ID_WIDTH terminates correctly.
  assign last_issue = issue && ((h_q + CW'(1)) == home_count);

  ref_index_bank #(
    .NUM_FILTER        (NUM_FILTER),
    .CELLS             (CELLS),
    .PARTICLE_ID_WIDTH (PARTICLE_ID_WIDTH)
  ) u_bank (
    .clk            (clk),
    .rst            (rst),
    .clear          (start_accept),
    .count_in       (cell_particle_count),
    .load           (load),
    .inc            (inc),
    .phase          (cur_phase),
    .home_count     (home_count),
    .ref0           (ref0),
    .ref_addr       (ref_rd_addr),
    .phase_all_done (phase_all_done),
    .broadcast_done (broadcast_done)
  );

  // Next-state, home index and bank control.
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    start_accept = 1'b0;
    load         = 1'b0;
    inc          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          start_accept = 1'b1;
          state_d      = (cell_particle_count[CW-1:0] == '0) ? StFinish : StLoad0;
        end
      end
      StLoad0: begin
        load    = 1'b1;
        h_d     = '0;
        state_d = phase_all_done ? StLoad1 : StSweep0;
      end
      StSweep0: begin
        if (issue) begin
          h_d = h_q + 1'b1;
        end
        if (last_issue) begin
          inc     = 1'b1;
          state_d = StLoad0;
        end
      end
      StLoad1: begin
        load    = 1'b1;
        h_d     = '0;
        state_d = phase_all_done ? StFinish : StSweep1;
      end
      StSweep1: begin
        if (issue) begin
          h_d = h_q + 1'b1;
        end
        if (last_issue) begin
          inc     = 1'b1;
          state_d = StLoad1;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state and home index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
    end
  end

  // Sideband delayed one cycle to line up with home RAM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_q <= 1'b1;
      phase_q <= 1'b0;
      rpr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pause_q <= ~issue;
      phase_q <= cur_phase;
      rpr_q   <= issue && !cur_phase && (h_q > ref0);
      done_q  <= (state_q == StFinish);
    end
  end

  assign home_rd_en        = issue;
  assign home_rd_addr      = issue ? h_q[PARTICLE_ID_WIDTH-1:0] : '0;
  assign ref_load          = load;
  assign busy              = (state_q != StIdle);
  assign phase             = phase_q;
  assign pause_reading     = pause_q;
  assign ref_particle_read = rpr_q;
  assign done              = done_q;

endmodule

// File: tb/tb_home_cell_read_controller.sv
// Directed bench for home_cell_read_controller: a cycle table for the basic
// sweep plus short hand-written sequences for the multi-cycle corner cases.
module tb_home_cell_read_controller;
  import md_pkg::*;

  localparam int NF = 7;
  localparam int NN = 13;
  localparam int PW = 7;
  localparam int NC = NN + 1;
  localparam int CW = PW + 1;
  localparam int NROWS = 22;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              back_pressure;
  logic [NC*CW-1:0]  cell_particle_count;
  logic              home_rd_en;
  logic [PW-1:0]     home_rd_addr;
  logic              ref_load;
  logic [NF*PW-1:0]  ref_rd_addr;
  logic              phase;
  logic              pause_reading;
  logic [NC-1:0]     broadcast_done;
  logic              ref_particle_read;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int cv[NC];

  typedef struct {
    logic             start;
    logic             bp;
    logic             en;
    logic [PW-1:0]    addr;
    logic             load;
    logic [NF*PW-1:0] refa;
    logic             pause;
    logic             rpr;
    logic             ph;
    logic             busy;
    logic             done;
    logic [NC-1:0]    bd;
  } vec_t;

  vec_t tab[NROWS];

  // Back-pressure sequence, cycle 0 is the start cycle.
  int bp_s[9]    = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
  int bp_en[9]   = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
  int bp_addr[9] = '{0, 0, 0, 1, 0, 0, 2, 3, 0};
  int bp_pause[9] = '{1, 1, 1, 0, 0, 1, 1, 0, 0};

  home_cell_read_controller #(
    .NUM_FILTER         (NF),
    .NUM_NEIGHBOR_CELLS (NN),
    .PARTICLE_ID_WIDTH  (PW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .cell_particle_count (cell_particle_count),
    .back_pressure       (back_pressure),
    .home_rd_en          (home_rd_en),
    .home_rd_addr        (home_rd_addr),
    .ref_load            (ref_load),
    .ref_rd_addr         (ref_rd_addr),
    .phase               (phase),
    .pause_reading       (pause_reading),
    .broadcast_done      (broadcast_done),
    .ref_particle_read   (ref_particle_read),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NF*PW-1:0] lanes(input int l0, input int lo);
    logic [NF*PW-1:0] v;
    int t;
    v = '0;
    for (int k = 0; k < NF; k++) begin
      t = (k == 0) ? l0 : lo;
      v[k*PW +: PW] = t[PW-1:0];
    end
    return v;
  endfunction

  function automatic vec_t row(input int st, input int bp, input int en, input int addr,
                               input int ld, input logic [NF*PW-1:0] rf, input int pa,
                               input int rp, input int ph, input int bu, input int dn,
                               input int bd);
    vec_t v;
    v.start = 1'(st);
    v.bp    = 1'(bp);
    v.en    = 1'(en);
    v.addr  = PW'(addr);
    v.load  = 1'(ld);
    v.refa  = rf;
    v.pause = 1'(pa);
    v.rpr   = 1'(rp);
    v.ph    = 1'(ph);
    v.busy  = 1'(bu);
    v.done  = 1'(dn);
    v.bd    = NC'(bd);
    return v;
  endfunction

  task automatic set_counts(input int home, input int others);
    int t;
    for (int i = 0; i < NC; i++) cv[i] = others;
    cv[0] = home;
  endtask

  task automatic pack_counts();
    int t;
    for (int i = 0; i < NC; i++) begin
      t = cv[i];
      cell_particle_count[i*CW +: CW] = t[CW-1:0];
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    back_pressure = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One cycle: drive inputs after the edge, then sample after settling.
  task automatic cycle(input logic st, input logic bp);
    @(posedge clk);
    #1;
    start = st;
    back_pressure = bp;
    #1;
  endtask

  task automatic run_basic(input int nrows);
    for (int i = 0; i < nrows; i++) begin
      cycle(tab[i].start, tab[i].bp);
      chk($sformatf("basic[%0d].home_rd_en", i), 64'(home_rd_en), 64'(tab[i].en));
      chk($sformatf("basic[%0d].home_rd_addr", i), 64'(home_rd_addr), 64'(tab[i].addr));
      chk($sformatf("basic[%0d].ref_load", i), 64'(ref_load), 64'(tab[i].load));
      if (tab[i].load) begin
        chk($sformatf("basic[%0d].ref_rd_addr", i), 64'(ref_rd_addr), 64'(tab[i].refa));
      end
      chk($sformatf("basic[%0d].pause_reading", i), 64'(pause_reading), 64'(tab[i].pause));
      chk($sformatf("basic[%0d].ref_particle_read", i), 64'(ref_particle_read),
          64'(tab[i].rpr));
      chk($sformatf("basic[%0d].phase", i), 64'(phase), 64'(tab[i].ph));
      chk($sformatf("basic[%0d].busy", i), 64'(busy), 64'(tab[i].busy));
      chk($sformatf("basic[%0d].done", i), 64'(done), 64'(tab[i].done));
      chk($sformatf("basic[%0d].broadcast_done", i), 64'(broadcast_done), 64'(tab[i].bd));
    end
    start = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".home_rd_en"}, 64'(home_rd_en), 64'd0);
    chk({tag, ".home_rd_addr"}, 64'(home_rd_addr), 64'd0);
    chk({tag, ".ref_load"}, 64'(ref_load), 64'd0);
    chk({tag, ".ref_rd_addr"}, 64'(ref_rd_addr), 64'd0);
    chk({tag, ".phase"}, 64'(phase), 64'd0);
    chk({tag, ".pause_reading"}, 64'(pause_reading), 64'd1);
    chk({tag, ".broadcast_done"}, 64'(broadcast_done), 64'd0);
    chk({tag, ".ref_particle_read"}, 64'(ref_particle_read), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int en_cnt;
    int late_en;
    int issues;
    int max_addr;
    int addr_bad;
    int last_ref0;
    int exp_h;
    bit seen_done;

    //            st bp en ad ld ref          pa rp ph bu dn bd
    tab[0]  = row(1, 0, 0, 0, 0, lanes(0, 0), 1, 0, 0, 0, 0, 'h0);
    tab[1]  = row(0, 0, 0, 0, 1, lanes(0, 0), 1, 0, 0, 1, 0, 'h0);
    tab[2]  = row(0, 0, 1, 0, 0, lanes(0, 0), 1, 0, 0, 1, 0, 'h0);
    tab[3]  = row(0, 0, 1, 1, 0, lanes(0, 0), 0, 0, 0, 1, 0, 'h0);
    tab[4]  = row(0, 0, 1, 2, 0, lanes(0, 0), 0, 1, 0, 1, 0, 'h0);
    tab[5]  = row(0, 0, 0, 0, 1, lanes(1, 1), 0, 1, 0, 1, 0, 'h0);
    tab[6]  = row(0, 0, 1, 0, 0, lanes(0, 0), 1, 0, 0, 1, 0, 'h7E);
    tab[7]  = row(0, 0, 1, 1, 0, lanes(0, 0), 0, 0, 0, 1, 0, 'h7E);
    tab[8]  = row(0, 0, 1, 2, 0, lanes(0, 0), 0, 0, 0, 1, 0, 'h7E);
    tab[9]  = row(0, 0, 0, 0, 1, lanes(2, 1), 0, 1, 0, 1, 0, 'h7E);
    tab[10] = row(0, 0, 1, 0, 0, lanes(0, 0), 1, 0, 0, 1, 0, 'h7E);
    tab[11] = row(0, 0, 1, 1, 0, lanes(0, 0), 0, 0, 0, 1, 0, 'h7E);
    tab[12] = row(0, 0, 1, 2, 0, lanes(0, 0), 0, 0, 0, 1, 0, 'h7E);
    tab[13] = row(0, 0, 0, 0, 1, lanes(3, 1), 0, 0, 0, 1, 0, 'h7E);
    tab[14] = row(0, 0, 0, 0, 1, lanes(0, 0), 1, 0, 0, 1, 0, 'h7F);
    tab[15] = row(0, 0, 1, 0, 0, lanes(0, 0), 1, 0, 1, 1, 0, 'h7F);
    tab[16] = row(0, 0, 1, 1, 0, lanes(0, 0), 0, 0, 1, 1, 0, 'h7F);
    tab[17] = row(0, 0, 1, 2, 0, lanes(0, 0), 0, 0, 1, 1, 0, 'h7F);
    tab[18] = row(0, 0, 0, 0, 1, lanes(1, 1), 0, 0, 1, 1, 0, 'h7F);
    tab[19] = row(0, 0, 0, 0, 0, lanes(0, 0), 1, 0, 1, 1, 0, 'h3FFF);
    tab[20] = row(0, 0, 0, 0, 0, lanes(0, 0), 1, 0, 0, 0, 1, 'h3FFF);
    tab[21] = row(0, 0, 0, 0, 0, lanes(0, 0), 1, 0, 0, 0, 0, 'h3FFF);

    // Reset values, checked while reset is still asserted.
    start = 1'b0;
    back_pressure = 1'b0;
    rst = 1'b1;
    set_counts(3, 1);
    pack_counts();
    #12;
    chk_reset_values("reset");
    do_reset();

    // Basic sweep.
    run_basic(NROWS);

    // Zero home count: done two cycles after start, no reads.
    do_reset();
    set_counts(0, 1);
    pack_counts();
    en_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(c == 0, 1'b0);
      if (home_rd_en) en_cnt++;
      if (c == 1) begin
        chk("zero.busy_c1", 64'(busy), 64'd1);
        chk("zero.done_c1", 64'(done), 64'd0);
      end
      if (c == 2) begin
        chk("zero.done_c2", 64'(done), 64'd1);
        chk("zero.busy_c2", 64'(busy), 64'd0);
      end
    end
    chk("zero.rd_en_count", 64'(en_cnt), 64'd0);

    // Back pressure after the second read.
    do_reset();
    set_counts(4, 0);
    pack_counts();
    for (int c = 0; c < 9; c++) begin
      cycle(c == 0, 1'(bp_s[c]));
      chk($sformatf("bp[%0d].home_rd_en", c), 64'(home_rd_en), 64'(bp_en[c]));
      chk($sformatf("bp[%0d].home_rd_addr", c), 64'(home_rd_addr), 64'(bp_addr[c]));
      chk($sformatf("bp[%0d].pause_reading", c), 64'(pause_reading), 64'(bp_pause[c]));
    end
    chk("bp.reload", 64'(ref_load), 64'd1);

    // Uneven counts: cell 3 exhausts after one round, cell 5 after two.
    do_reset();
    set_counts(1, 0);
    cv[3] = 1;
    cv[5] = 2;
    pack_counts();
    en_cnt = 0;
    late_en = 0;
    for (int c = 0; c < 9; c++) begin
      cycle(c == 0, 1'b0);
      if (home_rd_en) en_cnt++;
      if (home_rd_en && c >= 5) late_en++;
      if (c == 2) chk("uneven.bd_c2", 64'(broadcast_done), 64'h3FD6);
      if (c == 4) chk("uneven.bd_c4", 64'(broadcast_done), 64'h3FDF);
      if (c == 6) begin
        chk("uneven.bd_c6", 64'(broadcast_done), 64'h3FFF);
        chk("uneven.load1_c6", 64'(ref_load), 64'd1);
      end
      if (c == 7) chk("uneven.finish_busy", 64'(busy), 64'd1);
      if (c == 8) chk("uneven.done", 64'(done), 64'd1);
    end
    chk("uneven.rd_en_count", 64'(en_cnt), 64'd2);
    chk("uneven.phase1_reads", 64'(late_en), 64'd0);

    // Maximum home count: 128 rounds of 128 in phase 0, then one in phase 1.
    do_reset();
    set_counts(128, 0);
    cv[7] = 1;
    pack_counts();
    issues = 0;
    max_addr = 0;
    addr_bad = 0;
    last_ref0 = -1;
    exp_h = 0;
    seen_done = 1'b0;
    cycle(1'b1, 1'b0);
    for (int c = 0; c < 20000 && !seen_done; c++) begin
      cycle(1'b0, 1'b0);
      if (home_rd_en) begin
        issues++;
        if (int'(home_rd_addr) > max_addr) max_addr = int'(home_rd_addr);
        if (int'(home_rd_addr) != exp_h) addr_bad++;
        exp_h = (exp_h == 127) ? 0 : exp_h + 1;
      end
      if (ref_load) last_ref0 = int'(ref_rd_addr[PW-1:0]);
      if (done) seen_done = 1'b1;
    end
    chk("max.done_seen", 64'(seen_done), 64'd1);
    chk("max.issue_count", 64'(issues), 64'd16512);
    chk("max.max_addr", 64'(max_addr), 64'd127);
    chk("max.addr_sequence_errors", 64'(addr_bad), 64'd0);
    chk("max.r7_final", 64'(last_ref0), 64'd1);
    chk("max.bd7", 64'(broadcast_done[7]), 64'd1);
    chk("max.bd_all", 64'(broadcast_done), 64'h3FFF);

    // Mid-sweep reset, then an identical replay of the basic sweep.
    do_reset();
    set_counts(3, 1);
    pack_counts();
    run_basic(4);
    rst = 1'b1;
    #1;
    chk_reset_values("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_basic(NROWS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/home_cell_read_controller.md
# home_cell_read_controller

Sequencing controller that sits directly upstream of the position data distributor in the MD core. It generates home-cell position RAM read addresses and per-lane reference-particle load commands, and produces the distributor's sideband inputs: `phase`, `pause_reading`, `broadcast_done`, `ref_particle_read`. Each home-cell particle is swept once per reference round, in two phases of `NUM_FILTER` neighbour lanes each.

## Interface
**Parameters**
- `NUM_FILTER`, default 7: filter lanes per phase.
- `NUM_NEIGHBOR_CELLS`, default 13: neighbour cells. Cells 0..13, where cell 0 is home.
- `PARTICLE_ID_WIDTH`, default 7: particle index width. Counts are `PARTICLE_ID_WIDTH+1` bits wide.

**Ports**
- `clk`, in, 1: single clock; everything is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse; accepted only in IDLE.
- `cell_particle_count`, in, (NUM_NEIGHBOR_CELLS+1)*(PARTICLE_ID_WIDTH+1): particle count per cell, cell 0 in the LSBs; sampled on an accepted `start`.
- `back_pressure`, in, 1: downstream stall.
- `home_rd_en`, out, 1: home RAM read strobe.
- `home_rd_addr`, out, PARTICLE_ID_WIDTH: home particle index.
- `ref_load`, out, 1: pulse; lanes latch their new reference particle.
- `ref_rd_addr`, out, NUM_FILTER*PARTICLE_ID_WIDTH: reference index per lane.
- `phase`, out, 1: data-aligned phase.
- `pause_reading`, out, 1: high when no valid read data is present this cycle.
- `broadcast_done`, out, NUM_NEIGHBOR_CELLS+1: bit i set once cell i's references are exhausted.
- `ref_particle_read`, out, 1: home index > cell-0 reference index (Newton's-third-law dedup).
- `busy`, out, 1: FSM not in IDLE.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- **Reset values:** all outputs 0; `pause_reading`=1.
- **FSM states:** IDLE, LOAD0, SWEEP0, LOAD1, SWEEP1, FINISH.
- **IDLE:**
  - On `start`, latch the counts and clear `r[0..13]` and `broadcast_done`.
  - If home count = 0, go to FINISH.
  - Otherwise go to LOAD0.
- **LOADp:**
  - Assert `ref_load` for one cycle with `ref_rd_addr` lane k = `r[7p+k]`.
  - Set `broadcast_done[i]` where `r[i]` ≥ count[i].
  - If every bit of phase p is done, skip: LOAD0 goes to LOAD1, LOAD1 goes to FINISH.
  - Otherwise go to SWEEPp with home index h = 0.
- **SWEEPp:**
  - Each cycle with `back_pressure`=0: `home_rd_en`=1, `home_rd_addr`=h, then h++.
  - With `back_pressure`=1: `home_rd_en`=0 and h holds.
  - When h = homecount−1 is issued, increment every `r[i]` of phase p that is not done, then return to LOADp.
- **FINISH:** `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- An asynchronous `rst` in any state returns the block to IDLE with reset values. No partial `done` pulse.

## Timing
- Home RAM read latency is 1 cycle. `phase`, `ref_particle_read`, `broadcast_done`, and `pause_reading` are registered so they align with data 1 cycle after `home_rd_en`.
- `pause_reading` = NOT(`home_rd_en` from the previous cycle).
- `ref_particle_read` = (h > `r[0]`) AND phase 0, sampled at issue and delayed 1 cycle. It is 0 throughout phase 1.
- `broadcast_done` updates only in LOADp, so it is stable for a whole sweep.
- **Cycles per round:** 1 (LOAD) + homecount + stall cycles.
- A `back_pressure` asserted in cycle t blocks an issue in cycle t, so `pause_reading`=1 in cycle t+1.
- **Index arithmetic:** `r` and h are `PARTICLE_ID_WIDTH+1` bits wide. No wrap is possible; the terminal compare uses the full count width, so a count of 128 works.

## Structure
- **md_pkg additions:** constant `NUM_CELLS` (= NUM_NEIGHBOR_CELLS+1), `typedef enum logic [2:0] rdctl_state_t`, and a `count_t` typedef.
- **Sub-module `ref_index_bank`:** holds 14 reference counters, the increment-by-phase logic, and the `broadcast_done` compare. The top level holds the FSM, the h counter, and the alignment registers.

## Test plan
- **Basic sweep:** home=3, cells 1..13 = 1, cell 0 = 3 → phase 0 runs 3 rounds of 3 reads (addresses 0,1,2); `ref_particle_read` pattern per round is 0,1,1 / 0,0,1 / 0,0,0; `done` appears 1 cycle after the phase-1 round.
- **Zero home count:** home=0 → `done` 2 cycles after `start`; `home_rd_en` never asserted.
- **Back pressure:** home=4, `back_pressure` held high for 2 cycles after the second read → addresses 0,1 then 2 cycles idle then 2,3; `pause_reading`=1 on the 2 aligned cycles.
- **Uneven counts:** cell 3 count=1, cell 5 count=2, others 0 → `broadcast_done[3]` set in the second LOAD0, `broadcast_done[5]` set in the third; phase 1 is skipped entirely.
- **Max count:** home=128, cell 7=1 → `home_rd_addr` reaches 127; `r[7]` goes to 1; `broadcast_done[7]`=1; no wrap.
- **Mid-sweep reset:** assert `rst` during SWEEP0 → outputs are at reset values immediately; a new `start` replays the sequence identically.
